// File: rtl/pwm_multi_channel_pkg.sv
// pwm_pkg: shared widths, counter type and count-direction encoding for the PWM block
package pwm_pkg;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 4;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
endpackage

// File: rtl/pwm_multi_channel_if.sv
// pwm_wr_if: write bus into the period and per-channel duty shadow registers
interface pwm_wr_if
  import pwm_pkg::*;
#(
  parameter int CH_N  = 4,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int CH_W = (CH_N > 1) ? $clog2(CH_N) : 1;
  logic             per_wr;
  logic [CNT_W-1:0] per_val;
  logic             duty_wr;
  logic [CH_W-1:0]  duty_ch;
  logic [CNT_W-1:0] duty_val;
  modport master (output per_wr, per_val, duty_wr, duty_ch, duty_val);
  modport slave  (input  per_wr, per_val, duty_wr, duty_ch, duty_val);
endinterface

// File: rtl/pwm_multi_channel_ch.sv
// pwm_channel: double-buffered duty register and registered compare for one PWM output
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);
  logic [CNT_W-1:0] duty_shd_q, duty_shd_d, duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;
  // Shadow takes writes; active loads the pre-edge shadow on a period boundary
  always_comb begin
    duty_shd_d = wr ? wr_val : duty_shd_q;
    duty_act_d = ld ? duty_shd_q : duty_act_q;
    pwm_d      = en & (duty_act_q > cnt);
  end
  // Duty registers and output flop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      duty_shd_q <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_shd_q <= duty_shd_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  assign pwm = pwm_q;
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM with shared prescaled period counter and double-buffered
// period/duty registers. Define PWM_CENTER_ALIGN_EN to add the `center` input (up/down counting).
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CH_N       = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PRESC_W    = DEF_PRESC_W,
  parameter int PERIOD_RST = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] cfg_presc,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic               center,
`endif
  pwm_wr_if.slave            wr,
  output logic [CH_N-1:0]    pwm,
  output logic               period_end,
  output logic [CNT_W-1:0]   cnt
);
  localparam int CH_W = (CH_N > 1) ? $clog2(CH_N) : 1;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, per_shd_q, per_shd_d, per_act_q, per_act_d;
  logic               period_end_q, period_end_d;
  logic               tick, boundary;
`ifdef PWM_CENTER_ALIGN_EN
  dir_e               dir_q, dir_d;
  logic               center_q, center_d;
`endif
  // Prescaler tick, period boundary and next counter/period state
  always_comb begin
    tick    = en & (presc_q >= cfg_presc);
    presc_d = (!en || tick) ? '0 : presc_q + 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
    boundary = tick & (center_q ? ((cnt_q == '0 && dir_q == DIR_DOWN) || per_act_q == '0)
                                : (cnt_q == per_act_q));
    center_d = (!en || boundary) ? center : center_q;
    dir_d    = (!en || boundary) ? DIR_UP
             : (tick && center_q && dir_q == DIR_UP && cnt_q == per_act_q) ? DIR_DOWN : dir_q;
    cnt_d    = !en ? '0
             : boundary ? ((center_q && center && per_shd_q != '0) ? CNT_W'(1) : '0)
             : !tick ? cnt_q
             : (center_q && dir_d == DIR_DOWN) ? cnt_q - 1'b1 : cnt_q + 1'b1;
`else
    boundary = tick & (cnt_q == per_act_q);
    cnt_d    = (!en || boundary) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
`endif
    period_end_d = boundary;
    per_shd_d    = wr.per_wr ? wr.per_val : per_shd_q;
    per_act_d    = boundary ? per_shd_q : per_act_q;
  end
  // Prescaler, counter and period registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      per_shd_q    <= CNT_W'(PERIOD_RST);
      per_act_q    <= CNT_W'(PERIOD_RST);
      period_end_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      per_shd_q    <= per_shd_d;
      per_act_q    <= per_act_d;
      period_end_q <= period_end_d;
    end
`ifdef PWM_CENTER_ALIGN_EN
  // Count direction and alignment mode latched for the running period
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dir_q    <= DIR_UP;
      center_q <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      center_q <= center_d;
    end
`endif
  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .ld     (boundary),
      .wr     (wr.duty_wr && wr.duty_ch == CH_W'(i)),
      .wr_val (wr.duty_val),
      .cnt    (cnt_q),
      .pwm    (pwm[i])
    );
  end
  assign cnt        = cnt_q;
  assign period_end = period_end_q;
endmodule
